// File: rtl/dcache_write_buffer_pkg.sv
// Shared constants, FSM state type and address helper for the dcache victim-line write buffer.
// Geometry defaults follow the 512-bit dcache line.
package dcache_write_buffer_pkg;

    localparam int CACHELINE_WIDTH = 512;
    localparam int WB_DEPTH        = 4;
    localparam int WB_LINE_WORDS   = CACHELINE_WIDTH / 32;

    localparam logic [2:0] AXI_SIZE_W     = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_WSTRB_FULL = 4'hf;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_AW   = 2'd1,
        WB_W    = 2'd2,
        WB_B    = 2'd3
    } wb_state_e;

    // Line-aligned base address: clears the byte offset inside one line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int line_words);
        return addr & ~(32'(line_words * 4) - 32'd1);
    endfunction

endpackage

// File: rtl/wb_line_fifo.sv
// Circular store of evicted lines: aligned addresses, line data, valid bits, pointers,
// and the refill-address comparators that keep a refill behind a pending write.
module wb_line_fifo
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int LINE_WORDS = WB_LINE_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [31:0]             push_addr,
    input  logic [LINE_WORDS*32-1:0] push_line,
    output logic                    push_ready,
    input  logic                    pop,
    output logic                    head_valid,
    output logic [31:0]             head_addr,
    output logic [LINE_WORDS*32-1:0] head_line,
    output logic                    any_valid,
    input  logic [31:0]             lk_addr,
    output logic                    lk_hit
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]              addr_mem [DEPTH];
    logic [LINE_WORDS*32-1:0] line_mem [DEPTH];
    logic [DEPTH-1:0]         valid;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;

    // Push only targets a free slot and pop only a valid one, so the two never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: the storage arrays carry no reset; a slot's contents are meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= line_base(push_addr, LINE_WORDS);
            line_mem[wr_ptr] <= push_line;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        lk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addr_mem[i] == line_base(lk_addr, LINE_WORDS))) begin
                lk_hit = 1'b1;
            end
        end
    end

    assign push_ready = ~valid[wr_ptr];
    assign head_valid = valid[rd_ptr];
    assign head_addr  = addr_mem[rd_ptr];
    assign head_line  = line_mem[rd_ptr];
    assign any_valid  = |valid;

endmodule

// File: rtl/dcache_write_buffer.sv
// Victim-line write buffer: absorbs dirty evictions and drains them oldest-first
// as one AXI INCR burst per line over AW/W/B.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH      = WB_DEPTH,
    parameter int LINE_WORDS = WB_LINE_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_addr,
    input  logic [LINE_WORDS*32-1:0] in_line,
    input  logic [31:0]              lk_addr,
    output logic                     lk_hit,
    output logic                     empty,
    output logic [31:0]              awaddr,
    output logic [3:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    wb_state_e                state, state_next;
    logic [CNT_W-1:0]         cnt, cnt_next;
    logic                     pop;
    logic                     head_valid;
    logic                     any_valid;
    logic [31:0]              head_addr;
    logic [LINE_WORDS*32-1:0] head_line;
    logic [31:0]              words [LINE_WORDS];

    wb_line_fifo #(
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (in_valid & in_ready),
        .push_addr  (in_addr),
        .push_line  (in_line),
        .push_ready (in_ready),
        .pop        (pop),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_line  (head_line),
        .any_valid  (any_valid),
        .lk_addr    (lk_addr),
        .lk_hit     (lk_hit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        case (state)
            WB_IDLE: begin
                if (head_valid) state_next = WB_AW;
            end
            WB_AW: begin
                if (awready) begin
                    state_next = WB_W;
                    cnt_next   = '0;
                end
            end
            WB_W: begin
                if (wready) begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == LAST_BEAT) state_next = WB_B;
                end
            end
            WB_B: begin
                // The entry stays lk_hit-visible until this write response retires it.
                if (bvalid) begin
                    pop        = 1'b1;
                    state_next = WB_IDLE;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            words[i] = head_line[i*32 +: 32];
        end
    end

    // Address and data depend only on the head slot and cnt, both frozen while a channel stalls.
    assign awvalid = (state == WB_AW);
    assign awaddr  = awvalid ? head_addr : 32'd0;
    assign awlen   = 4'(LINE_WORDS - 1);
    assign awsize  = AXI_SIZE_W;
    assign awburst = AXI_BURST_INCR;

    assign wvalid  = (state == WB_W);
    assign wdata   = wvalid ? words[cnt] : 32'd0;
    assign wstrb   = AXI_WSTRB_FULL;
    assign wlast   = wvalid && (cnt == LAST_BEAT);

    assign bready  = (state == WB_B);
    assign empty   = ~any_valid && (state == WB_IDLE);

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer: enqueued lines are expected back, in order,
// as 16-beat AXI bursts under several ready/valid patterns.
module tb_dcache_write_buffer;

    localparam int LW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0]      addr;
        logic [LW*32-1:0] line;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [31:0]       in_addr;
    logic [LW*32-1:0]  in_line;
    logic [31:0]       lk_addr;
    logic              lk_hit, empty;
    logic [31:0]       awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid, awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast, wvalid, wready;
    logic              bvalid, bready;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    logic             rand_mode = 1'b0, hold_aw = 1'b0, hold_b = 1'b0;
    logic             in_flight = 1'b0, aw_stall = 1'b0, w_stall = 1'b0;
    logic [31:0]      aw_hold, w_hold;
    logic [LW*32-1:0] cur_line;
    int               beat = 0, drained = 0, last_b_cyc = 0;

    dcache_write_buffer #(.DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_line(in_line), .lk_addr(lk_addr), .lk_hit(lk_hit), .empty(empty),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [LW*32-1:0] mk_line(input logic [31:0] base);
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) l[w*32 +: 32] = base + 32'(w);
        return l;
    endfunction

    // Memory-side slave: drives ready/response just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        awready = hold_aw ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        wready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        bvalid  = bready && !hold_b && (rand_mode ? ($urandom_range(0, 2) == 0) : 1'b1);
    end

    // Monitor: handshakes are judged at the falling edge and complete at the next rising edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (awvalid) begin
                if (aw_stall) check("awaddr_stable", 64'(awaddr), 64'(aw_hold));
                if (awready) begin
                    if (sb.size() == 0) begin
                        check("aw_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("awaddr", 64'(awaddr), 64'(e.addr & 32'hffff_ffc0));
                        check("awlen", 64'(awlen), 64'(LW - 1));
                        check("awsize_burst", 64'({awsize, awburst}), 64'({3'b010, 2'b01}));
                        cur_line = e.line;
                    end
                    in_flight = 1'b1;
                    beat      = 0;
                    aw_stall  = 1'b0;
                end else begin
                    aw_stall = 1'b1;
                    aw_hold  = awaddr;
                end
            end
            if (wvalid) begin
                if (w_stall) check("wdata_stable", 64'(wdata), 64'(w_hold));
                if (wready) begin
                    check("wdata", 64'(wdata), 64'(cur_line[beat*32 +: 32]));
                    check("wlast", 64'(wlast), 64'(beat == LW - 1));
                    check("wstrb", 64'(wstrb), 64'(4'hf));
                    beat++;
                    w_stall = 1'b0;
                end else begin
                    w_stall = 1'b1;
                    w_hold  = wdata;
                end
            end
            if (bready && bvalid) begin
                check("beats_per_burst", 64'(beat), 64'(LW));
                in_flight  = 1'b0;
                drained++;
                last_b_cyc = cyc + 1;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic enq(input logic [31:0] a, input logic [LW*32-1:0] l, output int acc);
        exp_t e;
        acc      = -1;
        lk_addr  = a;
        in_valid = 1'b1;
        in_addr  = a;
        in_line  = l;
        @(negedge clk);
        check("no_dup_lk_hit", 64'(lk_hit), 64'(0));
        for (int t = 0; t < 2000; t++) begin
            if (in_ready) begin
                e.addr = a;
                e.line = l;
                sb.push_back(e);
                acc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check("enq_timeout", 64'(1), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (empty && sb.size() == 0 && !in_flight) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 64'(done), 64'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int acc, d0, b0;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_line = '0; lk_addr = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_lk_hit", 64'(lk_hit), 64'(0));
        check("rst_valids", 64'({awvalid, wvalid, wlast, bready}), 64'(0));
        check("rst_awaddr", 64'(awaddr), 64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        @(posedge clk);
        #1;

        // 1: single line, no backpressure
        enq(32'h1fc0_1234, mk_line(32'hA0), acc);
        check("t1_awvalid_n", 64'(awvalid), 64'(0));
        @(posedge clk);
        #1;
        check("t1_awvalid_n1", 64'(awvalid), 64'(1));
        check("t1_awaddr_n1", 64'(awaddr), 64'(32'h1fc0_1200));
        wait_idle("t1_idle");
        check("t1_drained", 64'(drained), 64'(1));
        check("t1_empty", 64'(empty), 64'(1));

        // 2: fill past DEPTH with AW held off
        hold_aw = 1'b1;
        for (int i = 0; i < DEPTH; i++) enq(32'h0010_0000 + 32'(i * 64), mk_line(32'h100 * 32'(i + 1)), acc);
        @(negedge clk);
        check("t2_full", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        fork
            enq(32'h0010_1000, mk_line(32'h5500), acc);
            begin
                repeat (5) @(posedge clk);
                #1 hold_aw = 1'b0;
            end
        join
        check("t2_accept_after_b", 64'(acc), 64'(last_b_cyc + 1));
        wait_idle("t2_idle");
        check("t2_drained", 64'(drained), 64'(6));

        // 3: random backpressure on every channel
        rand_mode = 1'b1;
        for (int i = 0; i < 3; i++) enq(32'h2000_0000 + 32'(i * 128), mk_line($urandom), acc);
        wait_idle("t3_idle");
        rand_mode = 1'b0;
        @(posedge clk);
        #1;
        check("t3_drained", 64'(drained), 64'(9));

        // 4: refill lookup against a buffered line
        enq(32'h0000_4000, mk_line(32'h4400), acc);
        lk_addr = 32'h0000_403c;
        @(negedge clk);
        check("t4_hit_same_line", 64'(lk_hit), 64'(1));
        lk_addr = 32'h0000_4040;
        #1;
        check("t4_miss_next_line", 64'(lk_hit), 64'(0));
        lk_addr = 32'h0000_403c;
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bready && bvalid) begin
                check("t4_hit_at_b", 64'(lk_hit), 64'(1));
                seen = 1'b1;
                break;
            end
        end
        check("t4_b_seen", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        check("t4_hit_after_b", 64'(lk_hit), 64'(0));
        wait_idle("t4_idle");

        // 5: reset in the middle of a burst
        enq(32'h3000_0000, mk_line(32'h7000), acc);
        enq(32'h3000_0040, mk_line(32'h7100), acc);
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (wvalid && beat == 7) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_reached_beat7", 64'(seen), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_valids_low", 64'({awvalid, wvalid, bready}), 64'(0));
        check("t5_empty", 64'(empty), 64'(1));
        check("t5_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        sb.delete();
        in_flight = 1'b0; aw_stall = 1'b0; w_stall = 1'b0; beat = 0;
        @(posedge clk);
        #1;

        // 6: enqueue and B-pop in the same cycle at DEPTH-1 occupancy, with wrap
        d0 = drained;
        hold_aw = 1'b1;
        for (int i = 0; i < DEPTH; i++) enq(32'h0060_0000 + 32'(i * 64), mk_line(32'h600 * 32'(i + 1)), acc);
        b0 = drained;
        hold_aw = 1'b0;
        for (int t = 0; t < 200 && drained == b0; t++) @(posedge clk);
        #1 hold_b = 1'b1;
        @(negedge clk);
        check("t6_slot0_free", 64'(in_ready), 64'(1));
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (bready) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t6_in_b", 64'(seen), 64'(1));
        @(posedge clk);
        #1;
        hold_b = 1'b0; bvalid = 1'b1;
        in_valid = 1'b1; in_addr = 32'h0060_1000; in_line = mk_line(32'h6a00);
        @(negedge clk);
        check("t6_push_ready", 64'(in_ready), 64'(1));
        check("t6_pop_now", 64'(bready && bvalid), 64'(1));
        sb.push_back('{addr: 32'h0060_1000, line: mk_line(32'h6a00)});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("t6_slot1_free", 64'(in_ready), 64'(1));
        check("t6_not_empty", 64'(empty), 64'(0));
        wait_idle("t6_idle");
        check("t6_drained", 64'(drained - d0), 64'(DEPTH + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
